fir_pkt_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single low-pass FIR filter unit between NUM_CH sensor Avalon-ST sources. It grants one source at a time and passes that whole packet (header, samples, trailer) unchanged to the FIR unit's Avalon-ST sink. It reports the granted channel alongside the data. A stalled source is cut off by a watchdog so it cannot hold the filter.

---
 rtl/fir_arb_pkg.sv | 15 +
 rtl/fir_pkt_arbiter_rr_pick.sv | 33 +++
 rtl/fir_pkt_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_fir_pkt_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_arb_pkg.sv
// Shared types and defaults for the FIR packet arbiter.
//   arb_state_t     : one-hot arbiter state encoding
//   ABORT_WORD_DFLT : default data of the synthetic terminating beat
package fir_arb_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        GRANT = 4'b0010,
        ABORT = 4'b0100,
        FLUSH = 4'b1000
    } arb_state_t;

    localparam logic [15:0] ABORT_WORD_DFLT = 16'hDEAD;

endpackage

// File: rtl/fir_pkt_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
//   req     : request vector, one bit per source
//   last    : index granted most recently; search starts just after it
//   gnt_idx : first requesting index after last, wrapping modulo NUM_CH
//   gnt_vld : high when any request is present
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CW-1:0]     last,
    output logic [CW-1:0]     gnt_idx,
    output logic              gnt_vld
);

    logic [CW-1:0] idx;

    // Scan from the farthest offset down to the nearest so that the
    // closest requester after last is the one left standing.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = CW'((int'(last) + k) % NUM_CH);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one FIR filter between NUM_CH
// Avalon-ST sources. A granted packet passes through unchanged with no
// added latency; a stalled source is cut off by a watchdog, terminated
// with a synthetic eop beat carrying ABORT_WORD, and then drained.
//   clk, reset                       : clock, async active-high reset
//   in_valid/in_ready/in_sop/in_eop  : per-source Avalon-ST sinks
//   in_data                          : source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready/out_sop/out_eop/out_data : stream toward the FIR
//   out_channel                      : granted source, valid with out_valid
//   busy                             : arbiter not idle
//   timeout_err                      : pulse when the watchdog fires
//   drop_err                         : pulse when a stray beat is discarded
module fir_pkt_arbiter
    import fir_arb_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 1024,
    parameter logic [DATA_WIDTH-1:0] ABORT_WORD = DATA_WIDTH'(ABORT_WORD_DFLT),
    localparam int CW        = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH-1:0]            in_sop,
    input  logic [NUM_CH-1:0]            in_eop,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [CW-1:0]                out_channel,
    output logic                         busy,
    output logic                         timeout_err,
    output logic                         drop_err
);

    localparam int            WW      = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] grant_q, grant_d;
    logic [CW-1:0] last_q, last_d;
    logic [WW-1:0] wd_q, wd_d;

    logic [DATA_WIDTH-1:0] lane [NUM_CH];
    logic [DATA_WIDTH-1:0] g_data;
    logic                  g_valid, g_sop, g_eop;
    logic [CW-1:0]         req_idx, stray_idx;
    logic                  req_vld, stray_vld;
    logic [WW-1:0]         wd_inc;
    logic                  wd_last;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        assign lane[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign g_data  = lane[grant_q];
    assign g_valid = in_valid[grant_q];
    assign g_sop   = in_sop[grant_q];
    assign g_eop   = in_eop[grant_q];

    rr_pick #(.NUM_CH(NUM_CH), .CW(CW)) u_req_pick (
        .req     (in_valid & in_sop),
        .last    (last_q),
        .gnt_idx (req_idx),
        .gnt_vld (req_vld)
    );

    // Stray beats are discarded lowest index first: fixing last at the top
    // index makes the search start at 0.
    rr_pick #(.NUM_CH(NUM_CH), .CW(CW)) u_stray_pick (
        .req     (in_valid & ~in_sop),
        .last    (LAST_CH),
        .gnt_idx (stray_idx),
        .gnt_vld (stray_vld)
    );

    // Saturating watchdog increment.
    assign wd_inc  = (wd_q == '1) ? wd_q : wd_q + WW'(1);
    assign wd_last = (wd_q == WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_CH;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        wd_d        = wd_q;
        in_ready    = '0;
        out_valid   = 1'b0;
        out_sop     = 1'b0;
        out_eop     = 1'b0;
        out_data    = '0;
        out_channel = '0;
        timeout_err = 1'b0;
        drop_err    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (stray_vld) begin
                    in_ready[stray_idx] = 1'b1;
                    drop_err            = 1'b1;
                end
                if (req_vld) begin
                    grant_d = req_idx;
                    wd_d    = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                out_valid         = g_valid;
                out_sop           = g_sop;
                out_eop           = g_eop;
                out_data          = g_data;
                out_channel       = grant_q;
                in_ready[grant_q] = out_ready;
                if (g_valid && out_ready) begin
                    wd_d = '0;
                    if (g_eop) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end else if (wd_last) begin
                    timeout_err = 1'b1;
                    state_d     = ABORT;
                end else begin
                    wd_d = wd_inc;
                end
            end
            ABORT: begin
                out_valid   = 1'b1;
                out_eop     = 1'b1;
                out_data    = ABORT_WORD;
                out_channel = grant_q;
                if (out_ready) begin
                    wd_d    = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Swallow the rest of the aborted packet, bounded in time in
                // case the source never delivers its eop.
                in_ready[grant_q] = 1'b1;
                if ((g_valid && g_eop) || wd_last) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else begin
                    wd_d = wd_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        busy = (state_q != IDLE);

        // Outputs read as zero for the whole time reset is held, including
        // the cycle in which it is first asserted.
        if (reset) begin
            in_ready    = '0;
            out_valid   = 1'b0;
            out_sop     = 1'b0;
            out_eop     = 1'b0;
            out_data    = '0;
            out_channel = '0;
            busy        = 1'b0;
            timeout_err = 1'b0;
            drop_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_pkt_arbiter.sv
module tb_fir_pkt_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid, in_ready, in_sop, in_eop;
    logic [63:0] in_data;
    logic        out_valid, out_sop, out_eop, out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_channel;
    logic        busy, timeout_err, drop_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fir_pkt_arbiter #(
        .NUM_CH     (4),
        .DATA_WIDTH (16),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .out_channel (out_channel),
        .busy        (busy),
        .timeout_err (timeout_err),
        .drop_err    (drop_err)
    );

    typedef struct {
        logic [3:0]  v, s, e;
        logic [11:0] d;
        logic [27:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [27:0] ex(input logic ov, input logic os, input logic oe,
                                       input logic [15:0] od, input logic [1:0] och,
                                       input logic [3:0] ir, input logic b,
                                       input logic te, input logic de);
        return {ov, os, oe, od, och, ir, b, te, de};
    endfunction

    function automatic logic [27:0] outs();
        return {out_valid, out_sop, out_eop, out_data, out_channel, in_ready,
                busy, timeout_err, drop_err};
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                                input logic [11:0] d, input logic [27:0] exp);
        vec_t r;
        r.v = v; r.s = s; r.e = e; r.d = d; r.exp = exp;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Lane i carries {i, d} so the source of every forwarded word is visible.
    task automatic set_lanes(input logic [11:0] d);
        for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = {4'(i), d};
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                         input logic [11:0] d);
        in_valid = v; in_sop = s; in_eop = e;
        set_lanes(d);
    endtask

    task automatic cyc_chk(input string nm, input logic [27:0] e);
        @(negedge clk);
        chk(nm, outs(), e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'b0, 4'b0, 4'b0, 12'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int pos[4];
    int order[5] = '{0, 1, 2, 3, 0};
    int nsop, neop, last_eop, cur, nacc, bpos;

    initial begin
        // Reset state, with a stray beat present that must not leak out.
        reset = 1'b1;
        out_ready = 1'b1;
        drive(4'b1000, 4'b0, 4'b0, 12'h123);
        @(negedge clk);
        chk("reset_outs", outs(), 28'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(4'b0, 4'b0, 4'b0, 12'h0);

        // Stray beat, then a single 5-beat packet on ch2.
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, ex(0,0,0,16'h0,0,4'b0000,0,0,0)));
        tbl.push_back(mk(4'b1000, 4'b0000, 4'b0000, 12'h123, ex(0,0,0,16'h0,0,4'b1000,0,0,1)));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, ex(0,0,0,16'h0,0,4'b0000,0,0,0)));
        tbl.push_back(mk(4'b0100, 4'b0100, 4'b0000, 12'h0AA, ex(0,0,0,16'h0,0,4'b0000,0,0,0)));
        tbl.push_back(mk(4'b0100, 4'b0100, 4'b0000, 12'h0AA, ex(1,1,0,16'h20AA,2,4'b0100,1,0,0)));
        tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 12'h001, ex(1,0,0,16'h2001,2,4'b0100,1,0,0)));
        tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 12'h002, ex(1,0,0,16'h2002,2,4'b0100,1,0,0)));
        tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 12'h003, ex(1,0,0,16'h2003,2,4'b0100,1,0,0)));
        tbl.push_back(mk(4'b0100, 4'b0000, 4'b0100, 12'h0EE, ex(1,0,1,16'h20EE,2,4'b0100,1,0,0)));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 12'h000, ex(0,0,0,16'h0,0,4'b0000,0,0,0)));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d);
            cyc_chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Backpressure: 8-beat packet on ch0, out_ready toggling.
        bpos = 0;
        nacc = 0;
        for (int cyc = 0; cyc < 40 && bpos < 8; cyc++) begin
            in_valid = 4'b0001;
            in_sop   = {3'b0, bpos == 0};
            in_eop   = {3'b0, bpos == 7};
            in_data  = '0;
            in_data[15:0] = 16'(256 + bpos);
            out_ready = (cyc % 2 == 1);
            @(negedge clk);
            if (cyc == 0) chk("bp_idle_ready", in_ready, 4'b0000);
            else          chk("bp_ready", in_ready, {3'b0, out_ready});
            if (out_valid && out_ready) begin
                chk("bp_data", out_data, 16'(256 + nacc));
                nacc++;
            end
            if (in_ready[0]) bpos++;
            @(posedge clk);
            #1;
        end
        chk("bp_count", nacc, 8);
        out_ready = 1'b1;
        drive(4'b0, 4'b0, 4'b0, 12'h0);
        cyc_chk("bp_end", ex(0,0,0,16'h0,0,4'b0000,0,0,0));

        // Round-robin with all four sources requesting 3-beat packets.
        do_reset();
        for (int i = 0; i < 4; i++) pos[i] = 0;
        nsop = 0; neop = 0; last_eop = -10; cur = -1;
        for (int cyc = 0; cyc < 80 && neop < 5; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                in_valid[i] = 1'b1;
                in_sop[i]   = (pos[i] == 0);
                in_eop[i]   = (pos[i] == 2);
                in_data[i*16 +: 16] = 16'(i * 4096 + pos[i]);
            end
            out_ready = 1'b1;
            @(negedge clk);
            if (out_valid) begin
                if (out_sop && nsop < 5) begin
                    chk("rr_order", out_channel, order[nsop]);
                    if (nsop > 0) chk("rr_gap", cyc - last_eop, 2);
                    cur = order[nsop];
                    nsop++;
                end
                if (cur >= 0) chk("rr_data", out_data, 16'(cur * 4096 + pos[cur]));
                if (out_eop) begin
                    last_eop = cyc;
                    neop++;
                end
            end
            for (int i = 0; i < 4; i++) if (in_ready[i]) pos[i] = (pos[i] + 1) % 3;
            @(posedge clk);
            #1;
        end
        chk("rr_done", neop, 5);

        // Watchdog: ch1 sends sop + 2 beats and stalls.
        do_reset();
        out_ready = 1'b1;
        drive(4'b0010, 4'b0010, 4'b0, 12'h0AA);
        cyc_chk("to_req", ex(0,0,0,16'h0,0,4'b0000,0,0,0));
        cyc_chk("to_sop", ex(1,1,0,16'h10AA,1,4'b0010,1,0,0));
        drive(4'b0010, 4'b0, 4'b0, 12'h001);
        cyc_chk("to_b1", ex(1,0,0,16'h1001,1,4'b0010,1,0,0));
        drive(4'b0010, 4'b0, 4'b0, 12'h002);
        cyc_chk("to_b2", ex(1,0,0,16'h1002,1,4'b0010,1,0,0));
        drive(4'b0, 4'b0, 4'b0, 12'h000);
        for (int k = 1; k <= 16; k++)
            cyc_chk($sformatf("to_wait%0d", k), ex(0,0,0,16'h1000,1,4'b0010,1,k == 16,0));
        out_ready = 1'b0;
        cyc_chk("abort_hold", ex(1,0,1,16'hDEAD,1,4'b0000,1,0,0));
        out_ready = 1'b1;
        cyc_chk("abort_take", ex(1,0,1,16'hDEAD,1,4'b0000,1,0,0));
        drive(4'b0010, 4'b0, 4'b0, 12'h003);
        cyc_chk("flush_b3", ex(0,0,0,16'h0,0,4'b0010,1,0,0));
        drive(4'b0010, 4'b0, 4'b0010, 12'h0EE);
        cyc_chk("flush_eop", ex(0,0,0,16'h0,0,4'b0010,1,0,0));
        drive(4'b0, 4'b0, 4'b0, 12'h000);
        cyc_chk("flush_idle", ex(0,0,0,16'h0,0,4'b0000,0,0,0));

        // Reset asserted mid-packet on ch3.
        drive(4'b1000, 4'b1000, 4'b0, 12'h0AA);
        cyc_chk("rst_req", ex(0,0,0,16'h0,0,4'b0000,0,0,0));
        @(negedge clk);
        chk("rst_granted", outs(), ex(1,1,0,16'h30AA,3,4'b1000,1,0,0));
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_outs", outs(), 28'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc_chk("rst_idle", ex(0,0,0,16'h0,0,4'b0000,0,0,0));
        cyc_chk("rst_regrant", ex(1,1,0,16'h30AA,3,4'b1000,1,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
